// File: rtl/arduino_move_handler.sv
// arduino_move_handler: checks Arduino column commands and drops accepted tokens into the lowest free row.
// Define ARDUINO_MOVE_LATCH_EN to hold one command that arrives while a previous one is still in flight.
module arduino_move_handler #(
    parameter int ROWS = 6,
    parameter int COLS = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           col_arduino,
    input  logic                 arduino_valida_jugada,
    input  logic                 arduino_turn,
    input  logic                 clear_board,
    output logic                 place_valid,
    output logic [2:0]           place_row,
    output logic [2:0]           place_col,
    output logic                 move_error,
    output logic [1:0]           error_code,
    output logic                 overrun,
    output logic                 busy,
    output logic [ROWS*COLS-1:0] board_occ,
    output logic [ROWS*COLS-1:0] board_owner
);
    localparam int N  = ROWS * COLS;
    localparam int HW = $clog2(ROWS + 1);
    localparam logic [HW-1:0] ONE = HW'(1);

    typedef enum logic [1:0] {IDLE, CHECK, RESULT} state_t;

    state_t        state, state_nxt;
    logic [2:0]    cmd_col, pend_col;
    logic          pend_valid, start, store, drop, place_ok, err_ok;
    logic [1:0]    err_nxt;
    logic [HW-1:0] cur_h;
    logic [HW-1:0] height [COLS];
    logic [N-1:0]  place_mask;

    always_ff @(posedge clk)
        state <= (reset || clear_board) ? IDLE : state_nxt;

    always_comb
        state_nxt = (state == IDLE) ? (start ? CHECK : IDLE) : (state == CHECK) ? RESULT : IDLE;

    always_comb begin
        busy  = state != IDLE;
        start = !busy && (pend_valid || arduino_valida_jugada);
`ifdef ARDUINO_MOVE_LATCH_EN
        // In IDLE a pending command is consumed, so a simultaneous strobe takes its slot.
        store = arduino_valida_jugada && (busy ? !pend_valid : pend_valid);
`else
        store = 1'b0;
`endif
        drop  = arduino_valida_jugada && busy && !store;
        cur_h = '0;
        for (int i = 0; i < COLS; i++)
            if (int'(cmd_col) == i) cur_h = height[i];
        err_nxt = !arduino_turn ? 2'b11 :
                  (int'(cmd_col) >= COLS) ? 2'b01 :
                  (int'(cur_h) == ROWS) ? 2'b10 : 2'b00;
        place_ok   = state == CHECK && err_nxt == 2'b00 && !clear_board;
        err_ok     = state == CHECK && err_nxt != 2'b00 && !clear_board;
        place_mask = {{(N-1){1'b0}}, 1'b1} << (int'(cur_h) * COLS + int'(cmd_col));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            place_valid <= 1'b0;
            move_error  <= 1'b0;
            overrun     <= 1'b0;
            place_row   <= '0;
            place_col   <= '0;
            error_code  <= '0;
            cmd_col     <= '0;
            pend_col    <= '0;
            pend_valid  <= 1'b0;
            board_occ   <= '0;
            board_owner <= '0;
            for (int i = 0; i < COLS; i++) height[i] <= '0;
        end else begin
            place_valid <= place_ok;
            move_error  <= err_ok;
            overrun     <= drop && !clear_board;
            if (clear_board) begin
                pend_valid  <= 1'b0;
                board_occ   <= '0;
                board_owner <= '0;
                for (int i = 0; i < COLS; i++) height[i] <= '0;
            end else begin
                if (start) cmd_col <= pend_valid ? pend_col : col_arduino;
                if (store) pend_col <= col_arduino;
                pend_valid <= store || (pend_valid && busy);
                if (err_ok) error_code <= err_nxt;
                if (place_ok) begin
                    board_occ   <= board_occ | place_mask;
                    board_owner <= board_owner | place_mask;
                    place_row   <= 3'(cur_h);
                    place_col   <= cmd_col;
                    for (int i = 0; i < COLS; i++)
                        if (int'(cmd_col) == i) height[i] <= cur_h + ONE;
                end
            end
        end
    end
endmodule

// File: doc/arduino_move_handler.md
# arduino_move_handler

Consumes the column commands decoded from the Arduino SPI link and applies them to the Connect-4 board. Each command is checked (turn, range, full column), then dropped into the lowest free row. The block reports either a placement or an error code to the game controller. It sits directly downstream of the Arduino SPI slave and owns the per-column fill heights and the board occupancy/owner vectors.

## Interface
- `ROWS`, default 6: board rows; row 0 is the bottom.
- `COLS`, default 7: board columns; valid columns are 0..COLS-1.
- `clk` input 1: FPGA system clock; all logic on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `col_arduino` input 3: commanded column; sampled only while `arduino_valida_jugada`=1.
- `arduino_valida_jugada` input 1: 1-cycle new-command strobe.
- `arduino_turn` input 1: 1 = Arduino may move; sampled in CHECK.
- `clear_board` input 1: synchronous new-game clear.
- `place_valid` output 1: 1-cycle pulse; a token was placed.
- `place_row` output 3: row of the last placement.
- `place_col` output 3: column of the last placement.
- `move_error` output 1: 1-cycle pulse; the command was rejected.
- `error_code` output 2: 01 out of range, 10 column full, 11 not Arduino's turn; holds its value until the next error.
- `overrun` output 1: 1-cycle pulse; a command was dropped.
- `busy` output 1: high while not in IDLE.
- `board_occ` output ROWS*COLS: occupied flags, index = row*COLS+col.
- `board_owner` output ROWS*COLS: 1 = Arduino token; meaningful only where `board_occ`=1.

## Operation
- **Reset:** all outputs, heights, board vectors, pending buffer and FSM go to 0 / IDLE.
- **Heights:** one counter per column, range 0..ROWS.
  - Width is clog2(ROWS+1).
  - A counter increments only on a successful placement and never exceeds ROWS.
- **FSM states:** IDLE, CHECK, RESULT.
  - IDLE → CHECK on a strobe, or when a pending command exists; the pending command takes precedence.
  - The command column is captured into `cmd_col`.
  - CHECK → RESULT always.
  - RESULT → IDLE always.
- **CHECK evaluation,** in priority order:
  1. `arduino_turn`=0 → error 11.
  2. `cmd_col`≥COLS → error 01.
  3. height[`cmd_col`]==ROWS → error 10.
  4. Otherwise place the token at row = height[`cmd_col`]: set `board_occ` and `board_owner` bits, increment the height, load `place_row`/`place_col`.
- **Result pulses:** registered at the CHECK→RESULT edge, so `place_valid` or `move_error` is high for exactly the RESULT cycle.
- **No side effects on error:** a rejected command leaves board and heights unchanged.
- **Strobe while busy:** handled per Configuration.
- **`clear_board`:**
  - Zeroes heights, `board_occ`, `board_owner` and the pending buffer; FSM returns to IDLE.
  - Suppresses any pulse that would have been generated that cycle.
  - A strobe in the same cycle is discarded without `overrun`.
  - `place_row`, `place_col` and `error_code` keep their values.
- **`reset` vs `clear_board`:** `reset` overrides `clear_board`.

## Timing
- **Latency:** strobe in cycle T → `busy`=1 in T+1 and T+2 → `place_valid`/`move_error` in T+2, with board outputs already updated in T+2 → `busy`=0 and a new command accepted in T+3.
- **Throughput:** one command per 3 cycles.
- **`arduino_turn`:** sampled in T+1 (CHECK), not at the strobe.
- **Mutual exclusion:** `place_valid` and `move_error` are never high together.
- **`overrun` timing:** high the cycle after the dropped strobe.

## Configuration
- **`ARDUINO_MOVE_LATCH_EN` defined:** one-entry pending buffer.
  - A strobe while `busy` is stored when the buffer is empty.
  - A stored command starts from IDLE in T+3 of the current command; no bubble beyond the IDLE cycle.
  - A strobe while `busy` with the buffer full is dropped with `overrun`.
- **`ARDUINO_MOVE_LATCH_EN` undefined:** no buffer; every strobe while `busy` is dropped and pulses `overrun`.
- **Both builds:** a strobe in IDLE is never dropped.

## Test plan
- **Basic placement:** reset, `arduino_turn`=1, strobe col 3 at T → `place_valid` at T+2 with `place_row`=0, `place_col`=3; `board_occ` bit 3 = 1 and `board_owner` bit 3 = 1.
- **Column fill:**
  - Six commands to col 0 → rows 0..5 reported in order; `board_occ` bits 0,7,14,21,28,35 set.
  - Seventh command → `move_error` with `error_code`=10, board unchanged.
- **Error priority:** `arduino_turn`=0 with col 7 → `error_code`=11; `arduino_turn`=1 with col 7 → `error_code`=01; no `place_valid` in either case.
- **Back-to-back strobes:** strobes at T (col 2) and T+1 (col 4).
  - With `ARDUINO_MOVE_LATCH_EN`: placements at T+2 (col 2) and T+5 (col 4), no `overrun`.
  - Without it: only col 2 is placed, and `overrun` is high at T+2.
- **Clear during CHECK:** strobe col 5 at T, `clear_board` at T+1 → no pulse at T+2, board all zero, heights zero; the next strobe at col 5 places at row 0.
- **Reset mid-operation:** `reset` at T+1 after a strobe → all outputs 0 at T+2, FSM in IDLE, next command accepted normally.
